// File: rtl/counter_pkg.sv
// Shared types and defaults for the load/up-down counter.
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_WIDTH = 4;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/load_updown_counter_next_value.sv
// Next-count and wrap/saturate flag for the counter.
// COUNTER_SATURATE_EN: hold at the boundary instead of wrapping.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  cnt_op_e          op,
  input  cnt_dir_e         dir,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] next_count_c,
  output logic             wrap_c
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic at_boundary;

  always_comb begin
    next_count_c = count;
    wrap_c       = 1'b0;
    at_boundary  = 1'b0;
    case (op)
      OP_LOAD: next_count_c = data_in;
      OP_COUNT: begin
        at_boundary = (dir == CNT_UP) ? (count == ALL_ONES) : (count == '0);
        wrap_c      = at_boundary;
`ifdef COUNTER_SATURATE_EN
        if (!at_boundary) begin
          next_count_c = (dir == CNT_UP) ? count + ONE : count - ONE;
        end
`else
        next_count_c = (dir == CNT_UP) ? count + ONE : count - ONE;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_updown_counter.sv
// Up/down counter with parallel load, enable and terminal-count flags.
// Optional build macro: COUNTER_SATURATE_EN (saturate instead of wrap).
module load_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH       = COUNTER_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] data_out,
  output logic             at_max,
  output logic             at_min,
  output logic             tc
);

  cnt_op_e          op;
  cnt_dir_e         dir;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] next_count_c;
  logic             wrap_c;

  // Unknown load/enable fall through to hold rather than acting as requests.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (enable) begin
      op = OP_COUNT;
    end
  end

  assign dir = cnt_dir_e'(up_down);

  counter_next_value #(
    .WIDTH(WIDTH)
  ) u_next (
    .count       (count),
    .op          (op),
    .dir         (dir),
    .data_in     (data_in),
    .next_count_c(next_count_c),
    .wrap_c      (wrap_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RESET_VALUE;
      tc    <= 1'b0;
    end else begin
      count <= next_count_c;
      tc    <= wrap_c;
    end
  end

  assign data_out = count;
  assign at_max   = (count == '1);
  assign at_min   = (count == '0);

endmodule

// File: tb/tb_load_updown_counter.sv
// Self-checking bench for load_updown_counter (WIDTH=4, RESET_VALUE=0).
module tb_load_updown_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load;
  logic         enable;
  logic         up_down;
  logic [W-1:0] data_out;
  logic         at_max;
  logic         at_min;
  logic         tc;

  int passed = 0;
  int total  = 0;

  load_updown_counter #(
    .WIDTH(W),
    .RESET_VALUE(4'd0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .load    (load),
    .enable  (enable),
    .up_down (up_down),
    .data_out(data_out),
    .at_max  (at_max),
    .at_min  (at_min),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       en;
    logic       ud;
    int         din;
    int         exp_wrap;
    logic       tc_wrap;
    int         exp_sat;
    logic       tc_sat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input int exp_out, input logic exp_tc);
    check({name, ".data_out"}, int'(data_out), exp_out);
    check({name, ".tc"}, int'(tc), int'(exp_tc));
    check({name, ".at_max"}, int'(at_max), int'(exp_out == MAX));
    check({name, ".at_min"}, int'(at_min), int'(exp_out == 0));
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  int   m_cnt;
  logic m_tc;
  task automatic model(input logic r, input logic ld, input logic en, input logic ud, input int d);
    if (r) begin
      m_cnt = 0; m_tc = 1'b0;
    end else if (ld) begin
      m_cnt = d; m_tc = 1'b0;
    end else if (en) begin
      if (ud) begin
        m_tc  = (m_cnt == MAX);
        m_cnt = m_tc ? (SAT ? MAX : 0) : m_cnt + 1;
      end else begin
        m_tc  = (m_cnt == 0);
        m_cnt = m_tc ? (SAT ? 0 : MAX) : m_cnt - 1;
      end
    end else begin
      m_tc = 1'b0;
    end
  endtask

  initial begin
    //            ld   en   ud   din  wrap tcW  sat tcS
    vecs[0]  = '{1'b1,1'b1,1'b0, 10,  10,1'b0, 10,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,  3,  10,1'b0, 10,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0, 14,  14,1'b0, 14,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b1,  0,  15,1'b0, 15,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b1,  0,   0,1'b1, 15,1'b1};
    vecs[5]  = '{1'b0,1'b1,1'b1,  0,   1,1'b0, 15,1'b1};
    vecs[6]  = '{1'b1,1'b1,1'b1,  1,   1,1'b0,  1,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,  0,   0,1'b0,  0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b0,  0,  15,1'b1,  0,1'b1};
    vecs[9]  = '{1'b0,1'b1,1'b0,  0,  14,1'b0,  0,1'b1};
    vecs[10] = '{1'b1,1'b0,1'b0,  5,   5,1'b0,  5,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,  9,   5,1'b0,  5,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,  9,   5,1'b0,  5,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,  0,   6,1'b0,  6,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b0,  0,   5,1'b0,  5,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b1,  0,   6,1'b0,  6,1'b0};

    reset = 1'b1; load = 1'b0; enable = 1'b0; up_down = 1'b0; data_in = '0;
    #2;
    check_all("reset_pre_clock", 0, 1'b0);
    step();
    step();
    check_all("reset_held", 0, 1'b0);
    reset = 1'b0;
    step();
    check_all("reset_release_hold", 0, 1'b0);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      load = vecs[i].ld; enable = vecs[i].en; up_down = vecs[i].ud;
      data_in = W'(vecs[i].din);
      step();
      if (SAT) check_all($sformatf("vec%0d", i), vecs[i].exp_sat, vecs[i].tc_sat);
      else     check_all($sformatf("vec%0d", i), vecs[i].exp_wrap, vecs[i].tc_wrap);
    end

    // Asynchronous reset mid-cycle with count = 7
    load = 1'b1; enable = 1'b0; data_in = 4'd7;
    step();
    check_all("load7", 7, 1'b0);
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_all("async_reset_at7", 0, 1'b0);
    step();
    check_all("async_reset_edge", 0, 1'b0);
    reset = 1'b0; enable = 1'b0;
    step();
    check_all("post_reset_idle", 0, 1'b0);
    enable = 1'b1;
    step();
    check_all("post_reset_count", 1, 1'b0);

    // Reset clears a pending tc pulse immediately
    load = 1'b1; data_in = 4'd15;
    step();
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    step();
    check("tc_before_reset", int'(tc), 1);
    #2 reset = 1'b1;
    #1;
    check_all("tc_cleared_by_reset", 0, 1'b0);
    step();
    reset = 1'b0; enable = 1'b0;

    // Randomised run against the reference model
    m_cnt = 0; m_tc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic r, ld, en, ud;
      int   d;
      r  = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 3) != 0);
      ud = 1'($urandom_range(0, 1));
      d  = int'($urandom_range(0, MAX));
      reset = r; load = ld; enable = en; up_down = ud; data_in = W'(d);
      model(r, ld, en, ud, d);
      step();
      check_all($sformatf("rand%0d", i), m_cnt, m_tc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_updown_counter.md
Name: load_updown_counter

Overview:
- Parameterised synchronous up/down counter with parallel load and count enable.
- Sits behind the counter bus interface (data_in, load, enable, up_down, data_out), driven from a single clock domain.
- Provides the registered count plus terminal-count status flags for downstream control logic.

Parameters:
- WIDTH, 4, bit width of data_in and data_out; legal range 2..32.
- RESET_VALUE, 0, value loaded into the count on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel load value.
- load  input  1  when high, count <= data_in on next clk edge.
- enable  input  1  when high and load low, count steps by one on next clk edge.
- up_down  input  1  direction: 1 = increment, 0 = decrement.
- data_out  output  WIDTH  current registered count.
- at_max  output  1  combinational: data_out == all ones.
- at_min  output  1  combinational: data_out == 0.
- tc  output  1  registered one-cycle pulse on a counting step that wrapped or saturated.

Behaviour:
- Reset is asynchronous and active-high. While reset = 1: data_out = RESET_VALUE and tc = 0, regardless of clk.
- Removal of reset is recognised on the first rising clk edge where reset = 0.
- Priority per rising edge: reset > load > enable > hold.
- load = 1: data_out <= data_in; enable and up_down are ignored; tc <= 0. Latency is 1 cycle, so the value appears on data_out after the edge.
- load = 0, enable = 1, up_down = 1: data_out <= data_out + 1, modulo 2^WIDTH. At all ones it wraps to 0 and tc <= 1 for that cycle.
- load = 0, enable = 1, up_down = 0: data_out <= data_out - 1, modulo 2^WIDTH. At 0 it wraps to all ones and tc <= 1.
- load = 0, enable = 0: data_out holds and tc <= 0.
- tc is high for exactly one cycle per wrap/saturate event and is cleared on any non-wrapping cycle.
- up_down may change on any cycle. The new direction takes effect on the same edge; no pipeline.
- Reset asserted mid-count aborts immediately. After release, counting resumes from RESET_VALUE only when enable is sampled high.
- at_max and at_min are pure decodes of data_out. Both are valid during reset and reflect RESET_VALUE.
- Inputs are assumed synchronous to clk; no internal synchronisers.
- No X propagation: an unknown on load or enable must not be treated as a legal request. Synthesis intent is that all state is held in flops reset by reset.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined: counting saturates instead of wrapping. Up at all ones holds all ones; down at 0 holds 0. tc pulses on the first cycle a saturating step is attempted and on every subsequent attempted step while saturated. Load is unaffected.
- Undefined: modulo wrap-around as described in Behaviour.

Decomposition:
- Shared package counter_pkg holds:
  - localparam COUNTER_DEFAULT_WIDTH = 4
  - typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e
  - typedef enum logic [1:0] {OP_HOLD, OP_COUNT, OP_LOAD} cnt_op_e, used by the interface and the scoreboard
- Interface counter_interface:
  - carries clk as a port
  - carries data_in, load, enable, up_down, reset and data_out as signals
  - has driver and monitor clocking blocks
- One natural sub-module, counter_next_value: combinational. It computes the next count and the wrap/saturate flag from the current count, operation, direction and data_in. The top-level module holds the registers and the flag decode.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with count = 7 -> data_out = 0 immediately, tc = 0, at_min = 1.
- Load: data_in = 10, load = 1 for one cycle -> data_out = 10 after next edge; with enable = 1 and up_down = 0 also applied, data_out is still 10.
- Up count with wrap: load 14, enable = 1, up_down = 1 for 3 cycles -> data_out 15, 0, 1; tc high only on the 15->0 cycle; at_max high while data_out = 15.
- Down count with wrap: load 1, enable = 1, up_down = 0 for 3 cycles -> data_out 0, 15, 14; tc high only on the 0->15 cycle.
- Hold and direction switch: load 5; enable = 0 for 2 cycles -> 5, 5; enable = 1 with up_down toggling 1, 0, 1 -> 6, 5, 6.
- COUNTER_SATURATE_EN build: load 14, count up 3 cycles -> 15, 15, 15 with tc high on the 2nd and 3rd cycles; load 1, count down 3 cycles -> 0, 0, 0.
